issue_select_scheduler: RTL and testbench

//  Issue-queue scheduler for one functional unit. Holds SIZE pending micro-ops.

---
 rtl/issue_select_scheduler_pkg.sv | 19 +
 rtl/issue_select_scheduler_if.sv | 34 +++
 rtl/issue_slot.sv | 84 ++++++++
 rtl/select_left_most.sv | 23 ++
 rtl/issue_select_scheduler.sv | 117 +++++++++++
 tb/tb_issue_select_scheduler.sv | 298 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/issue_select_scheduler_pkg.sv
// Shared types and default sizes for the issue-select scheduler.
// Optional feature macro used elsewhere in this slice: WAKEUP_SELECT_BYPASS_EN.
package issue_select_scheduler_pkg;

    localparam int unsigned DefSize = 8;
    localparam int unsigned DefTagW = 6;
    localparam int unsigned DefOpW  = 16;

    typedef logic [$clog2(DefSize)-1:0] slot_idx_t;

    // Architectural view of one queue entry at default widths.
    typedef struct packed {
        logic                    valid;
        logic [1:0][DefTagW-1:0] src_tag;
        logic [1:0]              src_rdy;
        logic [DefOpW-1:0]       op;
    } slot_t;

endpackage

// File: rtl/issue_select_scheduler_if.sv
// Dispatch / wakeup / issue bundle for the issue-select scheduler.
// master = environment side (dispatch, writeback, FU), slave = scheduler.
interface issue_select_scheduler_if
    import issue_select_scheduler_pkg::*;
#(
    parameter int unsigned SIZE  = DefSize,
    parameter int unsigned TAG_W = DefTagW,
    parameter int unsigned OP_W  = DefOpW
);
    logic                    flush;
    logic                    alloc_valid;
    logic                    alloc_ready;
    logic [2*TAG_W-1:0]      alloc_src;
    logic [1:0]              alloc_rdy;
    logic [OP_W-1:0]         alloc_op;
    logic                    wb_valid;
    logic [TAG_W-1:0]        wb_tag;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [$clog2(SIZE)-1:0] iss_slot;
    logic [$clog2(SIZE):0]   occupancy;

    modport master (
        output flush, alloc_valid, alloc_src, alloc_rdy, alloc_op, wb_valid, wb_tag, iss_ready,
        input  alloc_ready, iss_valid, iss_op, iss_slot, occupancy
    );

    modport slave (
        input  flush, alloc_valid, alloc_src, alloc_rdy, alloc_op, wb_valid, wb_tag, iss_ready,
        output alloc_ready, iss_valid, iss_op, iss_slot, occupancy
    );

endinterface

// File: rtl/issue_slot.sv
// One issue-queue entry: payload, two source tags with sticky ready bits,
// wakeup comparators and the select-ready output.
// WAKEUP_SELECT_BYPASS_EN: ready_o also honours this cycle's wakeup match.
module issue_slot
    import issue_select_scheduler_pkg::*;
#(
    parameter int unsigned TAG_W = DefTagW,
    parameter int unsigned OP_W  = DefOpW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               alloc_we_i,
    input  logic [2*TAG_W-1:0] alloc_src_i,
    input  logic [1:0]         alloc_rdy_i,
    input  logic [OP_W-1:0]    alloc_op_i,
    input  logic               wb_valid_i,
    input  logic [TAG_W-1:0]   wb_tag_i,
    input  logic               issue_clr_i,
    output logic               valid_o,
    output logic               ready_o,
    output logic [OP_W-1:0]    op_o
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [1:0]       rdy_q, rdy_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [1:0]       hit, alloc_hit;

    assign hit[0]       = wb_valid_i && (wb_tag_i == tag0_q);
    assign hit[1]       = wb_valid_i && (wb_tag_i == tag1_q);
    // Dispatch-time compare so a wakeup in the alloc cycle is never lost.
    assign alloc_hit[0] = wb_valid_i && (wb_tag_i == alloc_src_i[TAG_W-1:0]);
    assign alloc_hit[1] = wb_valid_i && (wb_tag_i == alloc_src_i[2*TAG_W-1:TAG_W]);

    // Next state: wakeup sets ready bits, issue frees, alloc overwrites, flush wins.
    always_comb begin
        valid_d = valid_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        rdy_d   = rdy_q | (hit & {2{valid_q}});
        op_d    = op_q;
        if (issue_clr_i) begin
            valid_d = 1'b0;
        end
        if (alloc_we_i) begin
            valid_d = 1'b1;
            tag0_d  = alloc_src_i[TAG_W-1:0];
            tag1_d  = alloc_src_i[2*TAG_W-1:TAG_W];
            rdy_d   = alloc_rdy_i | alloc_hit;
            op_d    = alloc_op_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            rdy_q   <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            rdy_q   <= rdy_d;
            op_q    <= op_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
`ifdef WAKEUP_SELECT_BYPASS_EN
    assign ready_o = valid_q && (&(rdy_q | hit));
`else
    assign ready_o = valid_q && (&rdy_q);
`endif

endmodule

// File: rtl/select_left_most.sv
// Priority picker: reports whether any request is set and the lowest set index.
module select_left_most #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IdxW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             found_o,
    output logic [IdxW-1:0]  idx_o
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/issue_select_scheduler.sv
// Issue-queue scheduler for one functional unit: lowest-free-slot allocation,
// tag wakeup, lowest-ready-slot select and a registered valid/ready issue stage.
// WAKEUP_SELECT_BYPASS_EN: select sees same-cycle wakeups (one edge earlier issue).
module issue_select_scheduler
    import issue_select_scheduler_pkg::*;
#(
    parameter int unsigned SIZE  = DefSize,
    parameter int unsigned TAG_W = DefTagW,
    parameter int unsigned OP_W  = DefOpW
) (
    input logic                      clk,
    input logic                      rst_n,
    issue_select_scheduler_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(SIZE);

    logic [SIZE-1:0] slot_valid, slot_ready, slot_we, slot_clr;
    logic [OP_W-1:0] slot_op [SIZE];
    logic            free_found, rdy_found;
    logic [IdxW-1:0] free_idx, rdy_idx;
    logic            alloc_fire, advance, issue_fire;
    logic            iss_valid_q, iss_valid_d;
    logic [OP_W-1:0] iss_op_q, iss_op_d;
    logic [IdxW-1:0] iss_slot_q, iss_slot_d;
    logic [IdxW:0]   occ;

    select_left_most #(.WIDTH(SIZE)) u_free_sel (
        .req_i   (~slot_valid),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    select_left_most #(.WIDTH(SIZE)) u_rdy_sel (
        .req_i   (slot_ready),
        .found_o (rdy_found),
        .idx_o   (rdy_idx)
    );

    // Flush dominates both the dispatch write and the issue pull.
    assign alloc_fire = bus.alloc_valid && free_found && !bus.flush;
    assign advance    = !iss_valid_q || bus.iss_ready;
    assign issue_fire = advance && rdy_found && !bus.flush;

    // Decode the chosen free / ready indices into per-slot strobes.
    always_comb begin
        slot_we  = '0;
        slot_clr = '0;
        for (int i = 0; i < SIZE; i++) begin
            slot_we[i]  = alloc_fire && (free_idx == IdxW'(i));
            slot_clr[i] = issue_fire && (rdy_idx == IdxW'(i));
        end
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_slot
        issue_slot #(.TAG_W(TAG_W), .OP_W(OP_W)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (bus.flush),
            .alloc_we_i  (slot_we[gi]),
            .alloc_src_i (bus.alloc_src),
            .alloc_rdy_i (bus.alloc_rdy),
            .alloc_op_i  (bus.alloc_op),
            .wb_valid_i  (bus.wb_valid),
            .wb_tag_i    (bus.wb_tag),
            .issue_clr_i (slot_clr[gi]),
            .valid_o     (slot_valid[gi]),
            .ready_o     (slot_ready[gi]),
            .op_o        (slot_op[gi])
        );
    end

    // Issue register next state: load on advance, hold otherwise, flush clears.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_slot_d  = iss_slot_q;
        if (advance) begin
            iss_valid_d = rdy_found;
            if (rdy_found) begin
                iss_op_d   = slot_op[rdy_idx];
                iss_slot_d = rdy_idx;
            end
        end
        if (bus.flush) begin
            iss_valid_d = 1'b0;
        end
    end

    // Issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_slot_q  <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_slot_q  <= iss_slot_d;
        end
    end

    // Occupancy counts queue slots only, not the issue register.
    always_comb begin
        occ = '0;
        for (int i = 0; i < SIZE; i++) begin
            occ = occ + (IdxW + 1)'(slot_valid[i]);
        end
    end

    assign bus.alloc_ready = free_found;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_op      = iss_op_q;
    assign bus.iss_slot    = iss_slot_q;
    assign bus.occupancy   = occ;

endmodule

// File: tb/tb_issue_select_scheduler.sv
// Self-checking bench for issue_select_scheduler: table of single-op alloc/wakeup
// vectors plus hand sequences for fill, backpressure, flush and async reset.
// Issued payloads are checked against a scoreboard queue by a negedge monitor.
module tb_issue_select_scheduler;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [15:0] sb [$];

    issue_select_scheduler_if #(.SIZE(8), .TAG_W(6), .OP_W(16)) bus ();

    issue_select_scheduler #(.SIZE(8), .TAG_W(6), .OP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  src1;
        logic [5:0]  src0;
        logic [1:0]  rdy;
        logic        wbv;
        logic [5:0]  wbt;
        logic [15:0] op;
        logic        exp_issue;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic [5:0] s1, input logic [5:0] s0, input logic [1:0] r,
                               input logic [15:0] op);
        bus.alloc_valid = 1'b1;
        bus.alloc_src   = {s1, s0};
        bus.alloc_rdy   = r;
        bus.alloc_op    = op;
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_occ", 32'(bus.occupancy), 0);
        chk("flush_iss_valid", 32'(bus.iss_valid), 0);
        sb.delete();
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst_n && bus.iss_valid && bus.iss_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected none", bus.iss_op);
            end else begin
                chk("sb_iss_op", 32'(bus.iss_op), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{6'd1,  6'd2, 2'b11, 1'b0, 6'd0,  16'h1000, 1'b1};
        vecs[1] = '{6'd5,  6'd3, 2'b01, 1'b1, 6'd5,  16'h1001, 1'b1};
        vecs[2] = '{6'd5,  6'd3, 2'b01, 1'b1, 6'd3,  16'h1002, 1'b0};
        vecs[3] = '{6'd7,  6'd9, 2'b10, 1'b1, 6'd9,  16'h1003, 1'b1};
        vecs[4] = '{6'd7,  6'd9, 2'b00, 1'b1, 6'd7,  16'h1004, 1'b0};
        vecs[5] = '{6'd4,  6'd4, 2'b00, 1'b1, 6'd4,  16'h1005, 1'b1};
        vecs[6] = '{6'd1,  6'd2, 2'b01, 1'b0, 6'd1,  16'h1006, 1'b0};
        vecs[7] = '{6'd63, 6'd0, 2'b10, 1'b1, 6'd0,  16'h1007, 1'b1};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_src = '0;
        bus.alloc_rdy = '0;
        bus.alloc_op  = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_tag    = '0;
        bus.iss_ready = 1'b1;
        step();
        step();
        chk("rst_iss_valid", 32'(bus.iss_valid), 0);
        chk("rst_iss_op", 32'(bus.iss_op), 0);
        chk("rst_iss_slot", 32'(bus.iss_slot), 0);
        chk("rst_occ", 32'(bus.occupancy), 0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
        rst_n = 1'b1;
        step();

        // Table: one op per vector, optional same-cycle wakeup.
        for (int v = 0; v < 8; v++) begin
            drive_alloc(vecs[v].src1, vecs[v].src0, vecs[v].rdy, vecs[v].op);
            bus.wb_valid = vecs[v].wbv;
            bus.wb_tag   = vecs[v].wbt;
            if (vecs[v].exp_issue) sb.push_back(vecs[v].op);
            step();
            idle();
            chk("vec_e1_occ", 32'(bus.occupancy), 1);
            chk("vec_e1_iss_valid", 32'(bus.iss_valid), 0);
            step();
            if (vecs[v].exp_issue) begin
                chk("vec_e2_iss_valid", 32'(bus.iss_valid), 1);
                chk("vec_e2_iss_slot", 32'(bus.iss_slot), 0);
                chk("vec_e2_iss_op", 32'(bus.iss_op), 32'(vecs[v].op));
                chk("vec_e2_occ", 32'(bus.occupancy), 0);
            end else begin
                chk("vec_e2_iss_valid", 32'(bus.iss_valid), 0);
                chk("vec_e2_occ", 32'(bus.occupancy), 1);
                do_flush();
            end
        end
        step();

        // Later wakeup: issue one edge after the wakeup edge (same edge with bypass).
        drive_alloc(6'd5, 6'd3, 2'b01, 16'h3001);
        step();
        idle();
        step();
        chk("wk_wait_iss_valid", 32'(bus.iss_valid), 0);
        chk("wk_wait_occ", 32'(bus.occupancy), 1);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd5;
        sb.push_back(16'h3001);
        step();
        idle();
`ifdef WAKEUP_SELECT_BYPASS_EN
        chk("wk_e1_iss_valid", 32'(bus.iss_valid), 1);
        chk("wk_e1_iss_op", 32'(bus.iss_op), 32'h3001);
        step();
        chk("wk_e2_iss_valid", 32'(bus.iss_valid), 0);
`else
        chk("wk_e1_iss_valid", 32'(bus.iss_valid), 0);
        chk("wk_e1_occ", 32'(bus.occupancy), 1);
        step();
        chk("wk_e2_iss_valid", 32'(bus.iss_valid), 1);
        chk("wk_e2_iss_op", 32'(bus.iss_op), 32'h3001);
`endif
        chk("wk_e2_occ", 32'(bus.occupancy), 0);
        step();

        // Back-to-back: alloc and issue on the same edge keep occupancy unchanged.
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h2000);
        sb.push_back(16'h2000);
        step();
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h2001);
        sb.push_back(16'h2001);
        step();
        idle();
        chk("b2b_e2_iss_slot", 32'(bus.iss_slot), 0);
        chk("b2b_e2_occ", 32'(bus.occupancy), 1);
        step();
        chk("b2b_e3_iss_slot", 32'(bus.iss_slot), 1);
        chk("b2b_e3_iss_op", 32'(bus.iss_op), 32'h2001);
        chk("b2b_e3_occ", 32'(bus.occupancy), 0);
        step();

        // Fill all slots with unready ops; ninth alloc must be ignored.
        for (int i = 0; i < 8; i++) begin
            drive_alloc(6'(10 + i), 6'(10 + i), 2'b00, 16'h4000 + 16'(i));
            step();
        end
        drive_alloc(6'd10, 6'd10, 2'b11, 16'h40FF);
        chk("full_alloc_ready", 32'(bus.alloc_ready), 0);
        chk("full_occ", 32'(bus.occupancy), 8);
        step();
        idle();
        chk("full_ignored_occ", 32'(bus.occupancy), 8);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd10;
        sb.push_back(16'h4000);
        step();
        idle();
        step();
        chk("full_after_issue_occ", 32'(bus.occupancy), 7);
        chk("full_after_issue_alloc_ready", 32'(bus.alloc_ready), 1);
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h4100);
        sb.push_back(16'h4100);
        step();
        idle();
        step();
        chk("reuse_iss_valid", 32'(bus.iss_valid), 1);
        chk("reuse_iss_slot", 32'(bus.iss_slot), 0);
        chk("reuse_iss_op", 32'(bus.iss_op), 32'h4100);
        step();
        chk("reuse_sb_drained", 32'(sb.size()), 0);
        do_flush();

        // Backpressure: slot 2 held in issue register, slot 5 follows on release.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_alloc(6'(20 + i), 6'd0, 2'b01, 16'h5000 + 16'(i));
            step();
        end
        idle();
        chk("bp_occ6", 32'(bus.occupancy), 6);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd22;
        sb.push_back(16'h5002);
        step();
        bus.wb_tag   = 6'd25;
        sb.push_back(16'h5005);
        step();
        idle();
        step();
        chk("bp_iss_valid", 32'(bus.iss_valid), 1);
        chk("bp_iss_slot", 32'(bus.iss_slot), 2);
        chk("bp_occ5", 32'(bus.occupancy), 5);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold_iss_op", 32'(bus.iss_op), 32'h5002);
            chk("bp_hold_iss_valid", 32'(bus.iss_valid), 1);
        end
        bus.iss_ready = 1'b1;
        step();
        chk("bp_rel_iss_slot", 32'(bus.iss_slot), 5);
        chk("bp_rel_iss_op", 32'(bus.iss_op), 32'h5005);
        chk("bp_rel_occ", 32'(bus.occupancy), 4);
        step();
        chk("bp_done_iss_valid", 32'(bus.iss_valid), 0);
        chk("bp_sb_drained", 32'(sb.size()), 0);
        do_flush();

        // Flush with queued ops and a held issue register drops a concurrent alloc.
        bus.iss_ready = 1'b0;
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h6000);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(6'(30 + i), 6'(30 + i), 2'b00, 16'h6001 + 16'(i));
            step();
        end
        idle();
        chk("fl_pre_iss_valid", 32'(bus.iss_valid), 1);
        chk("fl_pre_occ", 32'(bus.occupancy), 4);
        bus.flush = 1'b1;
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h60FF);
        step();
        idle();
        chk("fl_occ", 32'(bus.occupancy), 0);
        chk("fl_iss_valid", 32'(bus.iss_valid), 0);
        chk("fl_alloc_ready", 32'(bus.alloc_ready), 1);
        step();
        chk("fl_dropped_occ", 32'(bus.occupancy), 0);
        chk("fl_dropped_iss_valid", 32'(bus.iss_valid), 0);

        // Async reset mid-traffic clears state without waiting for a clock edge.
        drive_alloc(6'd1, 6'd2, 2'b11, 16'h7000);
        step();
        drive_alloc(6'd8, 6'd8, 2'b00, 16'h7001);
        step();
        drive_alloc(6'd9, 6'd9, 2'b00, 16'h7002);
        step();
        idle();
        chk("ar_pre_iss_valid", 32'(bus.iss_valid), 1);
        chk("ar_pre_occ", 32'(bus.occupancy), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_iss_valid", 32'(bus.iss_valid), 0);
        chk("ar_occ", 32'(bus.occupancy), 0);
        chk("ar_alloc_ready", 32'(bus.alloc_ready), 1);
        chk("ar_iss_op", 32'(bus.iss_op), 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        bus.iss_ready = 1'b1;
        step();
        chk("ar_post_occ", 32'(bus.occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
